// File: rtl/regfile_param.sv
// Parametrised integer register file with scoreboard,
// debug read port and sequenced bulk-clear engine.
module regfile_param #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            busy1,
  output logic            busy2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] ZERO = '0;
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t             state;
  state_t             state_nxt;
  logic [AW-1:0]      ptr;
  logic [AW-1:0]      ptr_nxt;
  logic [XLEN-1:0]    regs [NREG];
  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    busy_nxt;

  logic idle;
  logic take_clr;
  logic wr_en;
  logic iss_en;
  logic clr_en;
  logic byp1;
  logic byp2;

  assign idle     = (state == IDLE);
  assign take_clr = idle & clr_req;
  assign wr_en    = idle & ~clr_req & WE3 & (A3 != ZERO);
  assign iss_en   = iss_valid & (iss_rd != ZERO);
  assign clr_en   = (state == CLEAR);

  assign byp1 = WE3 & (A3 != ZERO) & (A3 == A1);
  assign byp2 = WE3 & (A3 != ZERO) & (A3 == A2);

  // Clear FSM state and sweep pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= ONE;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Clear FSM next-state: sweep r1..rNREG-1, then pulse done.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = ONE;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + ONE;
        if (ptr == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ptr_nxt   = ONE;
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = ONE;
      end
    endcase
  end

  // Storage: normal writes in IDLE, one zeroed entry per CLEAR cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end else if (clr_en) begin
      regs[ptr] <= '0;
    end
  end

  // Scoreboard next value: a new issue supersedes a completing write.
  always_comb begin
    busy_nxt = busy;
    if (idle) begin
      if (clr_req) begin
        busy_nxt = '0;
      end else begin
        if (WE3 && (A3 != ZERO)) begin
          busy_nxt[A3] = 1'b0;
        end
        if (iss_en) begin
          busy_nxt[iss_rd] = 1'b1;
        end
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read ports: bypass on matching write, forced zero outside IDLE/reset.
  always_comb begin
    RD1      = '0;
    RD2      = '0;
    dbg_data = '0;
    if (rst && idle) begin
      RD1      = byp1 ? WD3 : regs[A1];
      RD2      = byp2 ? WD3 : regs[A2];
      dbg_data = regs[dbg_addr];
    end
  end

  // Status outputs, all from registered state.
  always_comb begin
    busy1    = rst & busy[A1];
    busy2    = rst & busy[A2];
    clr_busy = rst & (state == CLEAR);
    clr_done = rst & (state == DONE);
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param
// (32x32 default instance and an 8x64 instance).
module tb_regfile_param;

  logic        clk;
  logic        rst;

  logic [4:0]  A1, A2, A3, iss_rd, dbg_addr;
  logic [31:0] RD1, RD2, WD3, dbg_data;
  logic        WE3, iss_valid, busy1, busy2;
  logic        clr_req, clr_busy, clr_done;

  logic [2:0]  bA1, bA2, bA3, biss_rd, bdbg_addr;
  logic [63:0] bRD1, bRD2, bWD3, bdbg_data;
  logic        bWE3, biss_valid, bbusy1, bbusy2;
  logic        bclr_req, bclr_busy, bclr_done;

  int checks = 0;
  int errors = 0;

  regfile_param u0 (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy1(busy1), .busy2(busy2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .clr_done(clr_done)
  );

  regfile_param #(.XLEN(64), .NREG(8)) u1 (
    .clk(clk), .rst(rst),
    .A1(bA1), .A2(bA2), .RD1(bRD1), .RD2(bRD2),
    .WE3(bWE3), .A3(bA3), .WD3(bWD3),
    .iss_valid(biss_valid), .iss_rd(biss_rd),
    .busy1(bbusy1), .busy2(bbusy2),
    .dbg_addr(bdbg_addr), .dbg_data(bdbg_data),
    .clr_req(bclr_req), .clr_busy(bclr_busy),
    .clr_done(bclr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int bcnt;
  int dcnt;
  logic [63:0] acc;
  logic [31:0] rd_in_clear;

  initial begin
    rst = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; WD3 = '0; WE3 = 1'b0;
    iss_valid = 1'b0; iss_rd = '0; dbg_addr = '0; clr_req = 1'b0;
    bA1 = '0; bA2 = '0; bA3 = '0; bWD3 = '0; bWE3 = 1'b0;
    biss_valid = 1'b0; biss_rd = '0; bdbg_addr = '0; bclr_req = 1'b0;

    // reset state
    tick();
    chk("rst_rd1", 64'(RD1), 64'h0);
    chk("rst_clr_busy", 64'(clr_busy), 64'h0);
    chk("rst_clr_done", 64'(clr_done), 64'h0);
    rst = 1'b1;
    tick();

    // read after reset
    A1 = 5'd5; A2 = 5'd0;
    settle();
    chk("read_r5", 64'(RD1), 64'h0);
    chk("read_r0", 64'(RD2), 64'h0);
    chk("busy_r5", 64'(busy1), 64'h0);

    // write with bypass
    WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h2004; A1 = 5'd9; dbg_addr = 5'd9;
    settle();
    chk("bypass_rd1", 64'(RD1), 64'h2004);
    chk("dbg_no_bypass", 64'(dbg_data), 64'h0);
    tick();
    WE3 = 1'b0;
    settle();
    chk("dbg_after_wr", 64'(dbg_data), 64'h2004);
    chk("rd1_after_wr", 64'(RD1), 64'h2004);

    // writes to x0 are discarded
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFF; A1 = 5'd0; A2 = 5'd0;
    settle();
    chk("x0_bypass", 64'(RD1), 64'h0);
    tick();
    WE3 = 1'b0; dbg_addr = 5'd0;
    settle();
    chk("x0_stored", 64'(dbg_data), 64'h0);

    // both ports bypass together
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'hABCD; A1 = 5'd3; A2 = 5'd3;
    settle();
    chk("dual_byp_rd1", 64'(RD1), 64'hABCD);
    chk("dual_byp_rd2", 64'(RD2), 64'hABCD);
    tick();
    WE3 = 1'b0;

    // scoreboard
    iss_valid = 1'b1; iss_rd = 5'd6; A1 = 5'd6;
    tick();
    iss_valid = 1'b0;
    settle();
    chk("sb_set", 64'(busy1), 64'h1);
    WE3 = 1'b1; A3 = 5'd6; WD3 = 32'h66;
    iss_valid = 1'b1; iss_rd = 5'd6;
    settle();
    chk("sb_no_bypass", 64'(busy1), 64'h1);
    tick();
    WE3 = 1'b0; iss_valid = 1'b0;
    settle();
    chk("sb_set_wins", 64'(busy1), 64'h1);
    WE3 = 1'b1; A3 = 5'd6; WD3 = 32'h67;
    tick();
    WE3 = 1'b0;
    settle();
    chk("sb_clear", 64'(busy1), 64'h0);
    iss_valid = 1'b1; iss_rd = 5'd0; A2 = 5'd0;
    tick();
    iss_valid = 1'b0;
    settle();
    chk("sb_x0", 64'(busy2), 64'h0);

    // asynchronous reset clears storage immediately
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h1234;
    tick();
    WE3 = 1'b0; dbg_addr = 5'd7;
    settle();
    chk("r7_loaded", 64'(dbg_data), 64'h1234);
    rst = 1'b0;
    #1;
    chk("async_rst_dbg", 64'(dbg_data), 64'h0);
    #1;
    rst = 1'b1;
    tick();
    chk("r7_after_rst", 64'(dbg_data), 64'h0);

    // bulk clear
    WE3 = 1'b1; A3 = 5'd1; WD3 = 32'h1;
    tick();
    A3 = 5'd31; WD3 = 32'hDEAD;
    tick();
    WE3 = 1'b0; dbg_addr = 5'd31;
    settle();
    chk("r31_loaded", 64'(dbg_data), 64'hDEAD);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    A1 = 5'd31;
    bcnt = 0; dcnt = 0; rd_in_clear = 32'hFFFF_FFFF;
    for (int c = 0; c < 60; c++) begin
      WE3 = (c == 2); A3 = 5'd5; WD3 = 32'h55;
      settle();
      if (clr_busy) bcnt++;
      if (clr_done) dcnt++;
      if (c == 5) rd_in_clear = RD1;
      tick();
    end
    WE3 = 1'b0;
    chk("clr_busy_cycles", 64'(bcnt), 64'd31);
    chk("clr_done_cycles", 64'(dcnt), 64'd1);
    chk("rd_during_clear", 64'(rd_in_clear), 64'h0);
    acc = '0;
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      acc = acc | 64'(dbg_data);
    end
    chk("all_zero_after_clr", acc, 64'h0);
    dbg_addr = 5'd5;
    #1;
    chk("r5_write_dropped", 64'(dbg_data), 64'h0);

    // clear aborted by reset
    WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h44;
    tick();
    WE3 = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("abort_in_clear", 64'(clr_busy), 64'h1);
    rst = 1'b0;
    #1;
    chk("abort_busy_low", 64'(clr_busy), 64'h0);
    tick();
    rst = 1'b1;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (clr_busy) bcnt++;
      if (clr_done) dcnt++;
    end
    chk("abort_no_busy", 64'(bcnt), 64'd0);
    chk("abort_no_done", 64'(dcnt), 64'd0);
    acc = '0;
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      acc = acc | 64'(dbg_data);
    end
    chk("abort_all_zero", acc, 64'h0);

    // 8x64 instance
    bWE3 = 1'b1; bA3 = 3'd7; bWD3 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bWE3 = 1'b0; bdbg_addr = 3'd7; bA1 = 3'd7;
    settle();
    chk("p_dbg_r7", bdbg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("p_rd1_r7", bRD1, 64'hFFFF_FFFF_FFFF_FFFF);
    bclr_req = 1'b1;
    tick();
    bclr_req = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bclr_busy) bcnt++;
      if (bclr_done) dcnt++;
      tick();
    end
    chk("p_clr_busy_cycles", 64'(bcnt), 64'd7);
    chk("p_clr_done_cycles", 64'(dcnt), 64'd1);
    chk("p_r7_cleared", bdbg_data, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised integer register file for the single-cycle core, and the successor of the fixed 32x32 register file.
- Provides two combinational read ports with same-cycle write bypass and one synchronous write port, with register 0 hardwired to zero.
- Adds a per-register busy scoreboard for future pipelined use, a combinational debug read port, and a sequenced bulk-clear engine.
- Sits between decode (read addresses), the writeback mux (write data) and debug/test logic.

Parameters:
XLEN, 32, data width of each register in bits
NREG, 32, number of registers; power of two, at least 4
AW, $clog2(NREG), address width (derived; not to be overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset
A1  input  AW  read port 1 address
A2  input  AW  read port 2 address
RD1  output  XLEN  read port 1 data
RD2  output  XLEN  read port 2 data
WE3  input  1  write enable
A3  input  AW  write address
WD3  input  XLEN  write data
iss_valid  input  1  mark register iss_rd busy (producer issued)
iss_rd  input  AW  register to mark busy
busy1  output  1  scoreboard busy bit for A1
busy2  output  1  scoreboard busy bit for A2
dbg_addr  input  AW  debug read address
dbg_data  output  XLEN  debug read data (no bypass)
clr_req  input  1  request bulk clear of all registers
clr_busy  output  1  high while clear sequence runs
clr_done  output  1  one-cycle pulse when clear completes

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - All NREG registers = 0; all busy bits = 0; FSM = IDLE; clear pointer = 1.
  - Outputs while rst=0: RD1 = RD2 = dbg_data = 0; busy1 = busy2 = clr_busy = clr_done = 0.
  - Reset asserted mid-clear aborts the sequence; after release the FSM is in IDLE and no clr_done pulse is produced.
- Register 0 always reads 0. Writes to address 0 are discarded. Issue to address 0 never sets a busy bit.
- Reads are combinational:
  - RDn = WD3 when WE3=1, A3=An and A3!=0 (write bypass); otherwise the stored value.
  - dbg_data = stored value only, with no bypass.
- Write: on a rising edge with WE3=1, A3!=0 and FSM=IDLE, Registers[A3] <= WD3.
- Scoreboard (FSM=IDLE only), evaluated on each rising edge:
  - WE3=1 with A3!=0 clears busy[A3].
  - iss_valid=1 with iss_rd!=0 sets busy[iss_rd].
  - If both address the same register in the same cycle, set wins (a new producer supersedes the completing one).
  - busyN = busy[An] from registered state; there is no bypass, so a same-cycle write does not hide busy.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on a rising edge with clr_req=1. On that edge all busy bits clear and ptr = 1.
  - CLEAR: each edge zeroes Registers[ptr] and increments ptr. On the edge that zeroes register NREG-1, go to DONE. CLEAR therefore lasts exactly NREG-1 cycles.
  - DONE: clr_done=1 for one cycle, then IDLE on the next edge with ptr reset to 1.
  - clr_busy=1 only in CLEAR.
  - While in CLEAR or DONE: WE3 writes and iss_valid are dropped (no effect on state); clr_req is ignored; RD1, RD2 and dbg_data return 0.
  - A write presented in the same cycle as the accepted clr_req is dropped.
  - clr_req held high in DONE does not retrigger; it is sampled again only in IDLE.
- A3=A1=A2 bypass applies to both ports simultaneously.
- No X propagation: every address in 0..NREG-1 is valid.

Test Plan:
- Reset then read: release rst; A1=5, A2=0 -> RD1=0, RD2=0, busy1=0; assert rst mid-run with Registers[7]=0x1234 -> dbg_data(7)=0 immediately, without waiting for a clock edge.
- Write/bypass/x0: WE3=1, A3=9, WD3=0x2004, A1=9 -> same-cycle RD1=0x2004, dbg_data(9)=old value (0); next cycle dbg_data(9)=0x2004. Then WE3=1, A3=0, WD3=0xFFFF -> RD for address 0 stays 0.
- Scoreboard: iss_valid=1, iss_rd=6 -> next cycle busy for A1=6 =1. Then WE3=1, A3=6, iss_valid=1, iss_rd=6 in the same cycle -> busy stays 1. Then write only -> busy=0. Then iss_rd=0 -> busy for address 0 =0.
- Bulk clear (NREG=32): preload r1=1, r31=0xDEAD; pulse clr_req -> clr_busy=1 for exactly 31 cycles, then clr_done=1 for exactly 1 cycle; all registers read 0 afterwards; a WE3 to r5 during CLEAR leaves r5=0.
- Clear abort: start clear, assert rst at CLEAR cycle 10 -> FSM in IDLE, clr_busy=0, clr_done never pulses, all registers 0.
- Parametric: NREG=8, XLEN=64 -> write 0xFFFF_FFFF_FFFF_FFFF to r7 reads back intact; clear takes 7 CLEAR cycles.
